// File: rtl/ram_dma_engine.sv
// Block-transfer engine driving a single-port word RAM: COPY, FILL and CHECKSUM
// over a wrapping address window, with one command in flight at a time.
module ram_dma_engine #(
  parameter int unsigned SIZE = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      cmd,
  input  logic [SIZE-1:0] src,
  input  logic [SIZE-1:0] dst,
  input  logic [SIZE:0]   len,
  input  logic [31:0]     fill_val,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [31:0]     checksum,
  output logic            mem_we,
  output logic [SIZE-1:0] mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic [31:0]     mem_rdata
);

  localparam int unsigned LW = SIZE + 1;
  localparam int unsigned DW = 32;

  localparam logic [1:0] CMD_COPY = 2'd0;
  localparam logic [1:0] CMD_FILL = 2'd1;
  localparam logic [1:0] CMD_SUM  = 2'd2;
  localparam logic [1:0] CMD_BAD  = 2'd3;

  typedef enum logic [2:0] {IDLE, RD, WR, SUM, DONE} state_t;

  state_t          state;
  logic [1:0]      cmd_q;
  logic [SIZE-1:0] src_q;
  logic [SIZE-1:0] dst_q;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   idx;
  logic [DW-1:0]   fill_q;
  logic [DW-1:0]   wdata_q;
  logic            wr_rdata;
  logic            addr_vld;
  logic            data_vld;

  logic [LW-1:0]   idx_nx;
  logic [SIZE-1:0] src_nx;
  logic [SIZE-1:0] dst_cur;
  logic [SIZE-1:0] dst_nx;
  logic            last;

  // Address arithmetic truncates to SIZE bits so blocks wrap past the top of memory.
  assign idx_nx  = idx + LW'(1);
  assign src_nx  = src_q + idx_nx[SIZE-1:0];
  assign dst_cur = dst_q + idx[SIZE-1:0];
  assign dst_nx  = dst_q + idx_nx[SIZE-1:0];
  assign last    = (idx_nx == len_q);

  // COPY write data is the RAM read of the previous cycle, so it bypasses the register.
  assign mem_wdata = wr_rdata ? mem_rdata : wdata_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cmd_q    <= CMD_COPY;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      fill_q   <= '0;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      checksum <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      wdata_q  <= '0;
      wr_rdata <= 1'b0;
      addr_vld <= 1'b0;
      data_vld <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      wdata_q  <= '0;
      wr_rdata <= 1'b0;
      addr_vld <= 1'b0;
      data_vld <= addr_vld;

      case (state)
        IDLE: begin
          if (start) begin
            cmd_q  <= cmd;
            src_q  <= src;
            dst_q  <= dst;
            len_q  <= len;
            fill_q <= fill_val;
            idx    <= '0;
            if (cmd == CMD_SUM) begin
              checksum <= '0;
            end
            if (cmd == CMD_BAD || len == '0) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= (cmd == CMD_BAD);
            end else begin
              busy <= 1'b1;
              case (cmd)
                CMD_COPY: begin
                  state    <= RD;
                  mem_addr <= src;
                end
                CMD_FILL: begin
                  state    <= WR;
                  mem_we   <= 1'b1;
                  mem_addr <= dst;
                  wdata_q  <= fill_val;
                end
                default: begin
                  state    <= SUM;
                  mem_addr <= src;
                  addr_vld <= 1'b1;
                end
              endcase
            end
          end
        end

        RD: begin
          state    <= WR;
          mem_we   <= 1'b1;
          mem_addr <= dst_cur;
          wr_rdata <= 1'b1;
        end

        WR: begin
          idx <= idx_nx;
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (cmd_q == CMD_COPY) begin
            state    <= RD;
            mem_addr <= src_nx;
          end else begin
            mem_we   <= 1'b1;
            mem_addr <= dst_nx;
            wdata_q  <= fill_q;
          end
        end

        // Reads issue back-to-back; each word lands one cycle after its address.
        SUM: begin
          if (data_vld) begin
            checksum <= checksum + mem_rdata;
          end
          if (addr_vld) begin
            idx <= idx_nx;
            if (!last) begin
              mem_addr <= src_nx;
              addr_vld <= 1'b1;
            end
          end else begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dma_engine.sv
// Directed bench for ram_dma_engine: behavioural RAM, shadow memory model and a
// write scoreboard checking address, data and cycle of every RAM write.
module tb_ram_dma_engine;

  localparam int unsigned SIZE  = 14;
  localparam int unsigned DEPTH = 2 ** SIZE;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      cmd = 2'd0;
  logic [SIZE-1:0] src = '0;
  logic [SIZE-1:0] dst = '0;
  logic [SIZE:0]   len = '0;
  logic [31:0]     fill_val = '0;
  logic            busy;
  logic            done;
  logic            err;
  logic [31:0]     checksum;
  logic            mem_we;
  logic [SIZE-1:0] mem_addr;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;

  always #5 clk = ~clk;

  ram_dma_engine #(.SIZE(SIZE)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cmd      (cmd),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .fill_val (fill_val),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .checksum (checksum),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Single-port RAM, registered read returning old data; host port borrows it while idle.
  logic [31:0]     ram [0:DEPTH-1];
  logic            h_en = 1'b0;
  logic            h_we = 1'b0;
  logic [SIZE-1:0] h_addr = '0;
  logic [31:0]     h_wdata = '0;

  always @(posedge clk) begin
    if (h_en ? h_we : mem_we) ram[h_en ? h_addr : mem_addr] <= h_en ? h_wdata : mem_wdata;
    mem_rdata <= ram[h_en ? h_addr : mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int              cyc;
    logic [SIZE-1:0] addr;
    logic [31:0]     data;
  } xact_t;

  xact_t       wr_q[$];
  xact_t       rd_q[$];
  xact_t       mon_e;
  logic [31:0] shadow [0:DEPTH-1];
  logic [31:0] ck_hold = '0;

  // Write monitor: every RAM write must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      n_chk++;
      assert (wr_q.size() != 0) else begin
        n_fail++;
        $error("FAIL wr_unexpected observed addr=%h data=%h expected no write", mem_addr, mem_wdata);
      end
      if (wr_q.size() != 0) begin
        mon_e = wr_q.pop_front();
        n_chk++;
        assert (cyc === mon_e.cyc) else begin
          n_fail++;
          $error("FAIL wr_cycle observed=%0d expected=%0d", cyc, mon_e.cyc);
        end
        n_chk++;
        assert (mem_addr === mon_e.addr) else begin
          n_fail++;
          $error("FAIL wr_addr observed=%h expected=%h", mem_addr, mon_e.addr);
        end
        n_chk++;
        assert (mem_wdata === mon_e.data) else begin
          n_fail++;
          $error("FAIL wr_data observed=%h expected=%h", mem_wdata, mon_e.data);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic hwrite(input logic [SIZE-1:0] a, input logic [31:0] d);
    @(negedge clk);
    h_en = 1'b1; h_we = 1'b1; h_addr = a; h_wdata = d;
    shadow[a] = d;
    @(negedge clk);
    h_en = 1'b0; h_we = 1'b0;
  endtask

  // Issue one command, queue its expected traffic, and check completion timing and flags.
  task automatic run_cmd(input string tag, input logic [1:0] c, input logic [SIZE-1:0] s,
                         input logic [SIZE-1:0] d, input logic [SIZE:0] l, input logic [31:0] f,
                         input int exp_done, input logic exp_err);
    int          base;
    int          k;
    logic [31:0] v;
    logic [31:0] sum;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    xact_t       x;
    @(negedge clk);
    start = 1'b1; cmd = c; src = s; dst = d; len = l; fill_val = f;
    base = cyc;
    sum  = '0;
    for (int i = 0; i < int'(l); i++) begin
      a = s + SIZE'(i);
      b = d + SIZE'(i);
      if (c == 2'd0) begin
        v = shadow[a];
        shadow[b] = v;
        rd_q.push_back('{base + 2 * i + 1, a, 32'd0});
        wr_q.push_back('{base + 2 * i + 2, b, v});
      end else if (c == 2'd1) begin
        shadow[b] = f;
        wr_q.push_back('{base + i + 1, b, f});
      end else if (c == 2'd2) begin
        sum = sum + shadow[a];
        rd_q.push_back('{base + i + 1, a, 32'd0});
      end
    end
    if (c == 2'd2) ck_hold = sum;
    @(negedge clk);
    start = 1'b0;
    for (k = 1; k <= 200; k++) begin
      if (k > 1) @(negedge clk);
      if (rd_q.size() != 0 && rd_q[0].cyc == cyc) begin
        x = rd_q.pop_front();
        check({tag, "_rd_addr"}, 32'(mem_addr), 32'(x.addr));
        check({tag, "_rd_we"}, 32'(mem_we), 32'd0);
      end
      if (k == 1 && exp_done > 1) check({tag, "_busy_c1"}, 32'(busy), 32'd1);
      if (done === 1'b1) break;
    end
    check({tag, "_done_cycle"}, 32'(cyc - base), 32'(exp_done));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_checksum"}, checksum, ck_hold);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_wr_left"}, 32'(wr_q.size()), 32'd0);
    check({tag, "_rd_left"}, 32'(rd_q.size()), 32'd0);
  endtask

  initial begin
    int  base;
    bit  seen_done;
    logic [31:0] a_val;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_checksum", checksum, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b1;

    // FILL and the untouched neighbours
    hwrite(14'h000F, 32'h1111_1111);
    hwrite(14'h0014, 32'h2222_2222);
    run_cmd("fill", 2'd1, 14'h0, 14'h0010, 15'd4, 32'hDEAD_BEEF, 5, 1'b0);
    check("fill_below", ram[14'h000F], 32'h1111_1111);
    check("fill_above", ram[14'h0014], 32'h2222_2222);

    // COPY of the filled block
    run_cmd("copy", 2'd0, 14'h0010, 14'h0020, 15'd4, 32'h0, 9, 1'b0);
    for (int i = 0; i < 4; i++) check("copy_ram", ram[14'h0020 + 14'(i)], 32'hDEAD_BEEF);

    // CHECKSUM wrapping past the top of memory
    hwrite(14'h3FFE, 32'd1);
    hwrite(14'h3FFF, 32'd2);
    hwrite(14'h0000, 32'hFFFF_FFFF);
    hwrite(14'h0001, 32'd5);
    run_cmd("sum_wrap", 2'd2, 14'h3FFE, 14'h0, 15'd4, 32'h0, 6, 1'b0);
    check("sum_value", checksum, 32'h0000_0007);

    // zero-length commands and the illegal command
    run_cmd("copy_len0", 2'd0, 14'h0010, 14'h0030, 15'd0, 32'h0, 1, 1'b0);
    run_cmd("fill_len0", 2'd1, 14'h0, 14'h0030, 15'd0, 32'h1234_5678, 1, 1'b0);
    run_cmd("bad_cmd_a", 2'd3, 14'h0010, 14'h0030, 15'd4, 32'h0, 1, 1'b1);
    run_cmd("sum_len0", 2'd2, 14'h0010, 14'h0, 15'd0, 32'h0, 1, 1'b0);
    run_cmd("bad_cmd_b", 2'd3, 14'h0010, 14'h0030, 15'd0, 32'h0, 1, 1'b1);

    // start while busy, then reset in the middle of a COPY
    for (int i = 0; i < 8; i++) begin
      hwrite(14'h0080 + 14'(i), 32'h0000_0100 + 32'(i));
      hwrite(14'h0090 + 14'(i), 32'hA0A0_0000 + 32'(i));
    end
    @(negedge clk);
    start = 1'b1; cmd = 2'd0; src = 14'h0080; dst = 14'h0090; len = 15'd8;
    base = cyc;
    for (int i = 0; i < 2; i++) begin
      shadow[14'h0090 + 14'(i)] = shadow[14'h0080 + 14'(i)];
      wr_q.push_back('{base + 2 * i + 2, 14'h0090 + 14'(i), shadow[14'h0080 + 14'(i)]});
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; cmd = 2'd1; fill_val = 32'h5555_5555;
    check("rst_mid_busy", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0; cmd = 2'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_we", 32'(mem_we), 32'd0);
    check("rst_mid_busy_after", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    rst = 1'b1;
    ck_hold = '0;
    seen_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("rst_mid_no_done", 32'(seen_done), 32'd0);
    check("rst_mid_checksum", checksum, ck_hold);
    check("rst_mid_wr_left", 32'(wr_q.size()), 32'd0);
    for (int i = 0; i < 8; i++) check("rst_mid_ram", ram[14'h0090 + 14'(i)], shadow[14'h0090 + 14'(i)]);

    // overlapping ascending COPY propagates the first word
    a_val = 32'hAAAA_0001;
    hwrite(14'h0040, a_val);
    hwrite(14'h0041, 32'hBBBB_0002);
    hwrite(14'h0042, 32'hCCCC_0003);
    hwrite(14'h0043, 32'hDDDD_0004);
    run_cmd("overlap", 2'd0, 14'h0040, 14'h0041, 15'd3, 32'h0, 7, 1'b0);
    for (int i = 1; i < 4; i++) check("overlap_ram", ram[14'h0040 + 14'(i)], a_val);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
